// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared defaults and the next-PC select encoding for the fetch
// stage program counter (pc_unit) and its return-address stack (pc_ras).
package pc_unit_pkg;

  localparam int          DEF_PC_W         = 32;
  localparam int          DEF_INC          = 4;
  localparam logic [63:0] DEF_RESET_VECTOR = 64'h0;

  // Source of the PC loaded on the next rising edge.
  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_RET    = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_BRANCH = 3'd4
  } pc_sel_e;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-control bundle between the pipeline and pc_unit.
//   Requests (master -> slave): pc_ena, branch_taken/branch_target,
//     jump_valid/jump_target, ret_valid, push_valid/push_addr.
//   Status (slave -> master): pc_out, pc_plus_inc, address_imem, pc_upper,
//     ras_top, ras_empty, ras_full, ret_miss.
interface pc_unit_if #(
  parameter int PC_W    = 32,
  parameter int IMEM_AW = 12,
  parameter int UPPER_W = 5
) ();
  logic               pc_ena;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic               jump_valid;
  logic [PC_W-1:0]    jump_target;
  logic               ret_valid;
  logic               push_valid;
  logic [PC_W-1:0]    push_addr;
  logic [PC_W-1:0]    pc_out;
  logic [PC_W-1:0]    pc_plus_inc;
  logic [IMEM_AW-1:0] address_imem;
  logic [UPPER_W-1:0] pc_upper;
  logic [PC_W-1:0]    ras_top;
  logic               ras_empty;
  logic               ras_full;
  logic               ret_miss;

  modport master (
    output pc_ena, branch_taken, branch_target, jump_valid, jump_target,
           ret_valid, push_valid, push_addr,
    input  pc_out, pc_plus_inc, address_imem, pc_upper, ras_top,
           ras_empty, ras_full, ret_miss
  );

  modport slave (
    input  pc_ena, branch_taken, branch_target, jump_valid, jump_target,
           ret_valid, push_valid, push_addr,
    output pc_out, pc_plus_inc, address_imem, pc_upper, ras_top,
           ras_empty, ras_full, ret_miss
  );
endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   push, pop    : stack operations (both together = replace top)
//   push_data    : address pushed / written over the top
//   top          : entry under the pointer (stale data when empty)
//   empty, full  : occupancy flags
// A push while full overwrites the oldest entry; a pop while empty is ignored.
module pc_ras #(
  parameter int PC_W      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [PC_W-1:0]  entry [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic [PTR_W-1:0] ptr_prv;
  logic [CNT_W-1:0] count;

  // Power-of-two depth makes the pointer wrap for free.
  assign ptr_nxt = ptr + PTR_W'(1);
  assign ptr_prv = ptr - PTR_W'(1);

  assign top   = entry[ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(RAS_DEPTH));

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entry[i] <= '0;
    end else if (push && (!pop || empty)) begin
      // Plain push; a tail call on an empty stack degenerates to this too.
      entry[ptr_nxt] <= push_data;
      ptr            <= ptr_nxt;
      if (!full) count <= count + CNT_W'(1);
    end else if (push && pop) begin
      // Tail call: swap the top in place.
      entry[ptr] <= push_data;
    end else if (pop && !empty) begin
      ptr   <= ptr_prv;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter, next-PC arbitration and RAS owner.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : stall/redirect requests in; PC, imem address, upper PC
//                  bits, PC+INC and RAS status out.
// Next-PC priority: branch > jump > return > sequential > hold.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter int              PC_W         = DEF_PC_W,
  parameter int              INC          = DEF_INC,
  parameter int              IMEM_AW      = 12,
  parameter int              UPPER_W      = 5,
  parameter int              RAS_DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_VECTOR = PC_W'(DEF_RESET_VECTOR)
) (
  input logic     clock,
  input logic     reset,
  pc_unit_if.slave bus
);

  logic [PC_W-1:0] pc_p1;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic            ret_miss_p1;

  pc_sel_e         sel;
  logic            ras_en;
  logic            ret_req;
  logic            ras_push;
  logic            ras_pop;
  logic            ret_miss_d;

  assign pc_inc = pc_p1 + PC_W'(INC);

  always_comb begin
    sel = SEL_HOLD;
    // A taken branch squashes the younger call/return in decode.
    ras_en  = bus.pc_ena & ~bus.branch_taken;
    // A simultaneous jump shadows the return completely.
    ret_req = ras_en & bus.ret_valid & ~bus.jump_valid;
    ras_push   = ras_en & bus.push_valid;
    ras_pop    = ret_req & ~ras_empty;
    ret_miss_d = ret_req & ras_empty;
    if (bus.branch_taken)                    sel = SEL_BRANCH;
    else if (bus.pc_ena && bus.jump_valid)   sel = SEL_JUMP;
    else if (ret_req && !ras_empty)          sel = SEL_RET;
    else if (bus.pc_ena)                     sel = SEL_SEQ;
  end

  pc_ras #(
    .PC_W      (PC_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (bus.push_addr),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  // Stage p1: registered PC and return-miss pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_p1       <= RESET_VECTOR;
      ret_miss_p1 <= 1'b0;
    end else begin
      ret_miss_p1 <= ret_miss_d;
      case (sel)
        SEL_BRANCH: pc_p1 <= bus.branch_target;
        SEL_JUMP:   pc_p1 <= bus.jump_target;
        SEL_RET:    pc_p1 <= ras_top;
        SEL_SEQ:    pc_p1 <= pc_inc;
        default:    pc_p1 <= pc_p1;
      endcase
    end
  end

  assign bus.pc_out       = pc_p1;
  assign bus.pc_plus_inc  = pc_inc;
  assign bus.address_imem = pc_p1[IMEM_AW-1:0];
  assign bus.pc_upper     = pc_p1[PC_W-1 -: UPPER_W];
  assign bus.ras_top      = ras_top;
  assign bus.ras_empty    = ras_empty;
  assign bus.ras_full     = ras_full;
  assign bus.ret_miss     = ret_miss_p1;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with hand-computed expectations for a 32-bit
// pc_unit and a 16-bit pc_unit; expectations are queued as stimulus is
// issued and a monitor compares them against the DUT outputs.
module tb_pc_unit;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_unit_if #(.PC_W(32), .IMEM_AW(12), .UPPER_W(5)) mb ();
  pc_unit_if #(.PC_W(16), .IMEM_AW(12), .UPPER_W(5)) nb ();

  pc_unit #(.PC_W(32)) u_dut (.clock(clock), .reset(reset), .bus(mb.slave));
  pc_unit #(.PC_W(16)) u_dut16 (.clock(clock), .reset(reset), .bus(nb.slave));

  typedef struct {
    int          id;
    bit          narrow;
    logic [31:0] pc;
    logic [31:0] inc;
    bit          chk_ras;
    bit          chk_top;
    logic [31:0] top;
    bit          empty;
    bit          full;
    bit          miss;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input int id, input string what,
                     input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL step %0d %s: got 0x%0h expected 0x%0h", id, what, act, exp);
    end
  endtask

  // Monitor: outputs only change at posedge, so the falling edge is stable.
  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.narrow) begin
        chk(e.id, "pc16", {16'h0, nb.pc_out}, e.pc);
        chk(e.id, "pc_plus_inc16", {16'h0, nb.pc_plus_inc}, e.inc);
      end else begin
        chk(e.id, "pc", mb.pc_out, e.pc);
        chk(e.id, "pc_plus_inc", mb.pc_plus_inc, e.inc);
        chk(e.id, "address_imem", {20'h0, mb.address_imem}, {20'h0, e.pc[11:0]});
        chk(e.id, "pc_upper", {27'h0, mb.pc_upper}, {27'h0, e.pc[31:27]});
        chk(e.id, "ret_miss", {31'h0, mb.ret_miss}, {31'h0, e.miss});
        if (e.chk_ras) begin
          chk(e.id, "ras_empty", {31'h0, mb.ras_empty}, {31'h0, e.empty});
          chk(e.id, "ras_full", {31'h0, mb.ras_full}, {31'h0, e.full});
        end
        if (e.chk_top) chk(e.id, "ras_top", mb.ras_top, e.top);
      end
    end
  end

  task automatic drv(input bit ena, input bit br, input logic [31:0] brt,
                     input bit jv, input logic [31:0] jt, input bit rv,
                     input bit pv, input logic [31:0] pa);
    mb.pc_ena = ena;  mb.branch_taken = br; mb.branch_target = brt;
    mb.jump_valid = jv; mb.jump_target = jt; mb.ret_valid = rv;
    mb.push_valid = pv; mb.push_addr = pa;
  endtask

  // Clock one edge and queue what the 32-bit DUT must show afterwards.
  task automatic step(input int id, input logic [31:0] pc, input bit chk_ras,
                      input bit chk_top, input logic [31:0] top,
                      input bit empty, input bit full, input bit miss);
    exp_t e;
    @(posedge clock); #1;
    e.id = id; e.narrow = 1'b0; e.pc = pc; e.inc = pc + 32'd4;
    e.chk_ras = chk_ras; e.chk_top = chk_top; e.top = top;
    e.empty = empty; e.full = full; e.miss = miss;
    q.push_back(e);
  endtask

  task automatic step16(input int id, input logic [31:0] pc, input logic [31:0] inc);
    exp_t e;
    @(posedge clock); #1;
    e = '{default: 0};
    e.id = id; e.narrow = 1'b1; e.pc = pc; e.inc = inc;
    q.push_back(e);
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    nb.pc_ena = 0; nb.branch_taken = 0; nb.branch_target = 0;
    nb.jump_valid = 0; nb.jump_target = 0; nb.ret_valid = 0;
    nb.push_valid = 0; nb.push_addr = 0;

    // Reset state
    reset = 1'b1;
    @(posedge clock); #1;
    drv(1, 1, 32'h5555, 1, 32'h6666, 1, 1, 32'h7777);  // ignored under reset
    step(0, 32'h0, 1, 1, 32'h0, 1, 0, 0);
    reset = 1'b0;

    // Sequential fetch
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 32'h4, 1, 0, 0, 1, 0, 0);
    step(2, 32'h8, 1, 0, 0, 1, 0, 0);
    step(3, 32'hC, 1, 0, 0, 1, 0, 0);
    step(4, 32'h10, 1, 0, 0, 1, 0, 0);

    // Stall holds PC and RAS even with jump/push requested
    drv(0, 0, 0, 1, 32'h80, 0, 1, 32'h999);
    step(5, 32'h10, 1, 0, 0, 1, 0, 0);
    step(6, 32'h10, 1, 0, 0, 1, 0, 0);
    // Branch overrides the stall
    drv(0, 1, 32'h200, 0, 0, 0, 0, 0);
    step(7, 32'h200, 1, 0, 0, 1, 0, 0);

    // Two calls, two returns, then a return on an empty stack
    drv(1, 0, 0, 0, 0, 0, 1, 32'h104);
    step(8, 32'h204, 1, 1, 32'h104, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 32'h208);
    step(9, 32'h208, 1, 1, 32'h208, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 0, 0);
    step(10, 32'h208, 1, 1, 32'h104, 0, 0, 0);
    step(11, 32'h104, 1, 0, 0, 1, 0, 0);
    step(12, 32'h108, 1, 0, 0, 1, 0, 1);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    step(13, 32'h10C, 1, 0, 0, 1, 0, 0);

    // Overfill: 0xA0 is overwritten by 0xB0
    drv(1, 0, 0, 0, 0, 0, 1, 32'hA0); step(14, 32'h110, 1, 1, 32'hA0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 32'hA4); step(15, 32'h114, 1, 1, 32'hA4, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 32'hA8); step(16, 32'h118, 1, 1, 32'hA8, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 32'hAC); step(17, 32'h11C, 1, 1, 32'hAC, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 32'hB0); step(18, 32'h120, 1, 1, 32'hB0, 0, 1, 0);
    drv(1, 0, 0, 0, 0, 1, 0, 0);
    step(19, 32'hB0, 1, 1, 32'hAC, 0, 0, 0);
    step(20, 32'hAC, 1, 1, 32'hA8, 0, 0, 0);
    step(21, 32'hA8, 1, 1, 32'hA4, 0, 0, 0);
    step(22, 32'hA4, 1, 0, 0, 1, 0, 0);
    step(23, 32'hA8, 1, 0, 0, 1, 0, 1);

    // Tail call: replace top, count unchanged
    drv(1, 0, 0, 0, 0, 0, 1, 32'h300);
    step(24, 32'hAC, 1, 1, 32'h300, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 1, 32'h400);
    step(25, 32'h300, 1, 1, 32'h400, 0, 0, 0);
    // Same with a branch: RAS untouched
    drv(1, 1, 32'h600, 0, 0, 1, 1, 32'h500);
    step(26, 32'h600, 1, 1, 32'h400, 0, 0, 0);
    // One pop empties it, proving count stayed at 1
    drv(1, 0, 0, 0, 0, 1, 0, 0);
    step(27, 32'h400, 1, 0, 0, 1, 0, 0);

    // Jump shadows a return: no pop
    drv(1, 0, 0, 0, 0, 0, 1, 32'h700);
    step(28, 32'h404, 1, 1, 32'h700, 0, 0, 0);
    drv(1, 0, 0, 1, 32'h900, 1, 0, 0);
    step(29, 32'h900, 1, 1, 32'h700, 0, 0, 0);

    // Reset beats a branch
    reset = 1'b1;
    drv(1, 1, 32'h1234, 0, 0, 0, 1, 32'h55);
    step(30, 32'h0, 1, 1, 32'h0, 1, 0, 0);
    reset = 1'b0;

    // Upper-bit export
    drv(0, 1, 32'hF800_0FF0, 0, 0, 0, 0, 0);
    step(31, 32'hF800_0FF0, 1, 0, 0, 1, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    step(32, 32'hF800_0FF4, 1, 0, 0, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);

    // 16-bit wrap
    nb.branch_taken = 1; nb.branch_target = 16'hFFFC;
    step16(40, 32'hFFFC, 32'h0);
    nb.branch_taken = 0; nb.pc_ena = 1;
    step16(41, 32'h0, 32'h4);
    step16(42, 32'h4, 32'h8);
    reset = 1'b1; nb.branch_taken = 1; nb.branch_target = 16'h1234;
    step16(43, 32'h0, 32'h4);
    reset = 1'b0; nb.branch_taken = 0; nb.pc_ena = 0;

    @(negedge clock);
    @(negedge clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
